// File: rtl/mydesign_ctrl_pkg.sv
// Shared definitions for the mydesign datapath sequencer: state encoding,
// default length width and the idle drive levels of the datapath controls.
package mydesign_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SH0   = 3'd1,
        S_SH1   = 3'd2,
        S_COUNT = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam int unsigned LEN_W_DEF = 4;

    // din1 is inverted inside the datapath, so 1 here shifts in a 0
    localparam logic DIN1_IDLE    = 1'b1;
    localparam logic UP1_DN0_IDLE = 1'b1;

endpackage

// File: rtl/mydesign_ctrl_shadow_cnt.sv
// 2-bit up/down counter mirroring the datapath counter; steps every cycle
// and wraps modulo 4.
module mydesign_ctrl_shadow_cnt (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       up1_dn0_i,
    output logic [1:0] cnt_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = up1_dn0_i ? cnt_q + 2'd1 : cnt_q - 2'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mydesign_seq_ctrl.sv
// Command-driven sequencer producing din1/up1_dn0/sel for the mydesign
// datapath: shift a 2-bit pattern, count for len cycles, set sel, pulse done.
module mydesign_seq_ctrl
    import mydesign_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_pattern,
    input  logic             cmd_dir,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_inv,
    input  logic             abort,
    output logic             din1,
    output logic             up1_dn0,
    output logic             sel,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [1:0]       shadow_cnt
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             pat1_q;
    logic             dir_q;
    logic             inv_q;
    logic             din1_q, up1_dn0_q, sel_q, done_q, aborted_q;
    logic             accept;
    logic             abort_hit;

    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:  if (cmd_valid) state_d = S_SH0;
            S_SH0:   state_d = S_SH1;
            S_SH1: begin
                if (len_q != '0) begin
                    state_d = S_COUNT;
                    cnt_d   = len_q;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_COUNT: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) state_d = S_HOLD;
            end
            S_HOLD:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // Outputs are registered from state_d so they line up with the state they
    // belong to. pattern[0] is consumed straight off the command bus on
    // acceptance, so only pattern[1] needs holding.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            pat1_q    <= 1'b0;
            dir_q     <= 1'b0;
            inv_q     <= 1'b0;
            din1_q    <= DIN1_IDLE;
            up1_dn0_q <= UP1_DN0_IDLE;
            sel_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                len_q  <= cmd_len;
                pat1_q <= cmd_pattern[1];
                dir_q  <= cmd_dir;
                inv_q  <= cmd_inv;
            end
            unique case (state_d)
                S_SH0:   din1_q <= ~cmd_pattern[0];
                S_SH1:   din1_q <= ~pat1_q;
                default: din1_q <= DIN1_IDLE;
            endcase
            up1_dn0_q <= (state_d == S_COUNT) ? dir_q : UP1_DN0_IDLE;
            if ((state_d == S_HOLD) && (state_q != S_HOLD)) sel_q <= inv_q;
            done_q    <= (state_d == S_DONE);
            aborted_q <= abort_hit;
        end
    end

    mydesign_ctrl_shadow_cnt u_shadow (
        .clk       (clk),
        .n_rst     (n_rst),
        .up1_dn0_i (up1_dn0_q),
        .cnt_o     (shadow_cnt)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign din1      = din1_q;
    assign up1_dn0   = up1_dn0_q;
    assign sel       = sel_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_mydesign_seq_ctrl.sv
// Directed bench for mydesign_seq_ctrl with hand-computed per-cycle
// expectations for every control output and the shadow counter.
module tb_mydesign_seq_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_pattern;
    logic       cmd_dir;
    logic [3:0] cmd_len;
    logic       cmd_inv;
    logic       abort;
    logic       din1, up1_dn0, sel, busy, done, aborted;
    logic [1:0] shadow_cnt;
    logic [1:0] ref_cnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    mydesign_seq_ctrl #(.LEN_W(4)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_pattern (cmd_pattern),
        .cmd_dir     (cmd_dir),
        .cmd_len     (cmd_len),
        .cmd_inv     (cmd_inv),
        .abort       (abort),
        .din1        (din1),
        .up1_dn0     (up1_dn0),
        .sel         (sel),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .shadow_cnt  (shadow_cnt)
    );

    // Stand-in for the datapath counter, driven by the controller's up1_dn0
    mydesign_ctrl_shadow_cnt u_ref (
        .clk       (clk),
        .n_rst     (n_rst),
        .up1_dn0_i (up1_dn0),
        .cnt_o     (ref_cnt)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic expect_st(input string tag, input logic e_din1, input logic e_up,
                             input logic e_sel, input logic e_busy, input logic e_done,
                             input logic e_ab, input logic [1:0] e_sh);
        check({tag, ".din1"},    8'(din1),       8'(e_din1));
        check({tag, ".up1_dn0"}, 8'(up1_dn0),    8'(e_up));
        check({tag, ".sel"},     8'(sel),        8'(e_sel));
        check({tag, ".busy"},    8'(busy),       8'(e_busy));
        check({tag, ".ready"},   8'(cmd_ready),  8'(!e_busy));
        check({tag, ".done"},    8'(done),       8'(e_done));
        check({tag, ".aborted"}, 8'(aborted),    8'(e_ab));
        check({tag, ".shadow"},  8'(shadow_cnt), 8'(e_sh));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] p, input logic d, input logic [3:0] l, input logic i);
        cmd_valid   = 1'b1;
        cmd_pattern = p;
        cmd_dir     = d;
        cmd_len     = l;
        cmd_inv     = i;
    endtask

    // Drop valid and scramble the fields so latching is exercised
    task automatic release_cmd;
        cmd_valid   = 1'b0;
        cmd_pattern = ~cmd_pattern;
        cmd_dir     = ~cmd_dir;
        cmd_len     = ~cmd_len;
        cmd_inv     = ~cmd_inv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0; cmd_valid = 1'b0; cmd_pattern = '0; cmd_dir = 1'b0;
        cmd_len = '0; cmd_inv = 1'b0; abort = 1'b0;
        #12;
        expect_st("reset", 1, 1, 0, 0, 0, 0, 2'd0);
        #10;
        n_rst = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            tick;
            expect_st("idle", 1, 1, 0, 0, 0, 0, 2'(i));
        end

        // pattern 10, down, len 3, inv 1
        send(2'b10, 1'b0, 4'd3, 1'b1);
        tick; release_cmd;
        expect_st("c1.sh0",  1, 1, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c1.sh1",  0, 1, 0, 1, 0, 0, 2'd3);
        tick; expect_st("c1.cnt1", 1, 0, 0, 1, 0, 0, 2'd0);
        tick; expect_st("c1.cnt2", 1, 0, 0, 1, 0, 0, 2'd3);
        tick; expect_st("c1.cnt3", 1, 0, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c1.hold", 1, 1, 1, 1, 0, 0, 2'd1);
        tick; expect_st("c1.done", 1, 1, 1, 1, 1, 0, 2'd2);
        tick; expect_st("c1.idle", 1, 1, 1, 0, 0, 0, 2'd3);

        // len 0 skips COUNT
        send(2'b01, 1'b1, 4'd0, 1'b0);
        tick; release_cmd;
        expect_st("c2.sh0",  0, 1, 1, 1, 0, 0, 2'd0);
        tick; expect_st("c2.sh1",  1, 1, 1, 1, 0, 0, 2'd1);
        tick; expect_st("c2.hold", 1, 1, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c2.done", 1, 1, 0, 1, 1, 0, 2'd3);
        tick; expect_st("c2.idle", 1, 1, 0, 0, 0, 0, 2'd0);

        // maximum length, down, from shadow 1
        tick; expect_st("c3.pre",  1, 1, 0, 0, 0, 0, 2'd1);
        send(2'b11, 1'b0, 4'd15, 1'b0);
        tick; release_cmd;
        expect_st("c3.sh0",  0, 1, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c3.sh1",  0, 1, 0, 1, 0, 0, 2'd3);
        for (int i = 1; i <= 15; i++) begin
            tick;
            expect_st("c3.cnt", 1, 0, 0, 1, 0, 0, 2'(17 - i));
            check("c3.vs_datapath", 8'(shadow_cnt), 8'(ref_cnt));
        end
        tick; expect_st("c3.hold", 1, 1, 0, 1, 0, 0, 2'd1);
        tick; expect_st("c3.done", 1, 1, 0, 1, 1, 0, 2'd2);
        tick; expect_st("c3.idle", 1, 1, 0, 0, 0, 0, 2'd3);

        // abort in the second COUNT cycle, then accept with abort still high
        send(2'b11, 1'b1, 4'd5, 1'b1);
        tick; release_cmd;
        expect_st("c4.sh0",  0, 1, 0, 1, 0, 0, 2'd0);
        tick; expect_st("c4.sh1",  0, 1, 0, 1, 0, 0, 2'd1);
        tick; expect_st("c4.cnt1", 1, 1, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c4.cnt2", 1, 1, 0, 1, 0, 0, 2'd3);
        abort = 1'b1;
        tick; expect_st("c4.abort", 1, 1, 0, 0, 0, 1, 2'd0);
        send(2'b00, 1'b1, 4'd1, 1'b1);
        tick; release_cmd; abort = 1'b0;
        expect_st("c5.sh0",  1, 1, 0, 1, 0, 0, 2'd1);
        tick; expect_st("c5.sh1",  1, 1, 0, 1, 0, 0, 2'd2);
        tick; expect_st("c5.cnt",  1, 1, 0, 1, 0, 0, 2'd3);
        tick; expect_st("c5.hold", 1, 1, 1, 1, 0, 0, 2'd0);
        tick; expect_st("c5.done", 1, 1, 1, 1, 1, 0, 2'd1);
        abort = 1'b1;
        tick; expect_st("c5.idle", 1, 1, 1, 0, 0, 0, 2'd2);
        abort = 1'b0;

        // asynchronous reset in COUNT
        send(2'b10, 1'b0, 4'd4, 1'b0);
        tick; release_cmd;
        expect_st("c6.sh0",  1, 1, 1, 1, 0, 0, 2'd3);
        tick; expect_st("c6.sh1",  0, 1, 1, 1, 0, 0, 2'd0);
        tick; expect_st("c6.cnt1", 1, 0, 1, 1, 0, 0, 2'd1);
        tick; expect_st("c6.cnt2", 1, 0, 1, 1, 0, 0, 2'd0);
        #2 n_rst = 1'b0;
        #1 expect_st("c6.rst", 1, 1, 0, 0, 0, 0, 2'd0);
        tick; expect_st("c6.rsthold", 1, 1, 0, 0, 0, 0, 2'd0);
        n_rst = 1'b1;
        tick; expect_st("c6.after", 1, 1, 0, 0, 0, 0, 2'd1);
        tick; expect_st("c6.after2", 1, 1, 0, 0, 0, 0, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
